param_digital_lock: RTL and testbench
=====================================

// Module: param_digital_lock
// PURPOSE
//  Parametrised keypad lock: N_DIGITS-digit BCD code, entered with position/increment buttons.
//  Adds on-chip retry counting, a timed lockout and runtime password change while unlocked.
//  Replaces the fixed 3-digit lock datapath. Sits behind the button debouncers and drives
//  the RGB status LED, the 7-seg digit bus and the tries-left LEDs.
// PARAMETERS
//  N_DIGITS       3              number of BCD digits in the code (>=1)
//  MAX_TRIES      3              wrong entries allowed before lockout (1..15)
//  LOCKOUT_CYC    625_000_000    lockout length in clk cycles (5 s at 125 MHz), >=1
//  DEFAULT_PASS   12'h122        password after reset, N_DIGITS*4 bits, BCD, digit0 = LSBs
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  pos_btn      in   1             1-cycle pulse: advance digit cursor
//  inc_btn      in   1             1-cycle pulse: increment digit under cursor
//  clr_btn      in   1             1-cycle pulse: clear entry buffer and cursor
//  enter_btn    in   1             1-cycle pulse: submit entry
//  mode         in   1             level: 1 = set-password mode (honoured only when unlocked)
//  entry        out  N_DIGITS*4    current entry buffer, BCD, to 7-seg
//  cursor       out  $clog2(N_DIGITS) (min 1)  digit position being edited
//  unlocked     out  1             1 while in UNLOCKED
//  lockout      out  1             1 while in LOCKOUT
//  tries_left   out  4             remaining attempts
//  led_rgb      out  3             {R,G,B}: LOCKED 100, UNLOCKED 010, LOCKOUT 001
// BEHAVIOUR
//  All outputs registered. Reset: state LOCKED, entry 0, cursor 0, tries_left MAX_TRIES,
//   stored pass DEFAULT_PASS, lockout counter 0, unlocked 0, lockout 0, led_rgb 100.
//  FSM states LOCKED, UNLOCKED, LOCKOUT. Buttons sampled on clk; effect visible next cycle.
//  Editing (LOCKED and UNLOCKED only):
//   - inc_btn: entry[cursor] 0..8 -> +1, 9 -> 0 (mod 10).
//   - pos_btn: cursor N_DIGITS-1 -> 0, else +1.
//   - inc+pos same cycle: increment applies to old cursor, cursor then advances.
//   - priority per cycle: clr_btn > enter_btn > inc/pos; a cycle with clr or enter does no edit.
//   - clr_btn: entry <= 0, cursor <= 0, no state change.
//  LOCKED + enter_btn (compare entry vs stored pass, full width):
//   - match: -> UNLOCKED, tries_left <= MAX_TRIES.
//   - mismatch, tries_left > 1: tries_left -= 1, stay LOCKED.
//   - mismatch, tries_left == 1: tries_left <= 0, -> LOCKOUT, counter <= LOCKOUT_CYC-1.
//   - entry and cursor cleared in every case.
//  UNLOCKED + enter_btn:
//   - mode=1: stored pass <= entry, stay UNLOCKED.
//   - mode=0: -> LOCKED (relock); stored pass unchanged.
//   - entry and cursor cleared in both cases. mode toggling alone has no effect.
//  LOCKOUT: all buttons ignored (entry frozen at 0). Counter decrements each cycle;
//   in the cycle it reads 0: -> LOCKED, tries_left <= MAX_TRIES. Lockout lasts exactly
//   LOCKOUT_CYC cycles (lockout=1 for LOCKOUT_CYC cycles).
//  Counter width $clog2(LOCKOUT_CYC+1); never wraps (load only on LOCKOUT entry).
//  rst_n low at any time (mid-entry, mid-lockout) returns to reset values, including
//   stored pass back to DEFAULT_PASS.
//  Enter with no edits compares all-zero entry; valid code 000 is permitted.
// TESTING
//  T1 reset, 1x inc@pos0, 2x inc@pos1, 2x inc@pos2 (entry 12'h221)? no: build 12'h122, enter
//     -> next cycle unlocked=1, led_rgb=010, tries_left=3, entry=0.
//  T2 LOCKED, enter 12'h000 three times -> tries_left 2,1 then lockout=1, led_rgb=001;
//     use LOCKOUT_CYC=8: lockout high exactly 8 cycles, buttons ignored, then LOCKED, tries=3.
//  T3 unlocked, mode=1, enter 12'h957 -> stays unlocked; mode=0 enter -> LOCKED;
//     enter 12'h122 -> fails (tries 2); enter 12'h957 -> unlocked.
//  T4 inc 10x on digit0 -> digit0 = 0; pos 3x with N_DIGITS=3 -> cursor 0;
//     inc+pos same cycle at cursor 1 -> digit1 +1, cursor 2; clr+inc same cycle -> entry 0.
//  T5 rst_n low mid-lockout and after password change -> reset values, DEFAULT_PASS unlocks.
//  T6 re-run T1/T2 with N_DIGITS=5, MAX_TRIES=1, DEFAULT_PASS=20'h01234: one wrong -> LOCKOUT.

Source files
------------

// File: rtl/param_digital_lock_if.sv
// Keypad lock bundle: debounced button pulses and mode level in, display/status out.
// Master drives the buttons; slave is the lock and drives the status lines.
interface param_digital_lock_if #(
   parameter int N_DIGITS = 3
);
   localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic                  pos_btn;
   logic                  inc_btn;
   logic                  clr_btn;
   logic                  enter_btn;
   logic                  mode;
   logic [N_DIGITS*4-1:0] entry;
   logic [CW-1:0]         cursor;
   logic                  unlocked;
   logic                  lockout;
   logic [3:0]            tries_left;
   logic [2:0]            led_rgb;

   modport master (
      output pos_btn, inc_btn, clr_btn, enter_btn, mode,
      input  entry, cursor, unlocked, lockout, tries_left, led_rgb
   );

   modport slave (
      input  pos_btn, inc_btn, clr_btn, enter_btn, mode,
      output entry, cursor, unlocked, lockout, tries_left, led_rgb
   );
endinterface

// File: rtl/param_digital_lock.sv
// N-digit BCD keypad lock with retry counting, timed lockout and password change.
// Every button takes effect one cycle after it is sampled; no backpressure, buttons ignored in lockout.
module param_digital_lock #(
   parameter int                        N_DIGITS     = 3,
   parameter int                        MAX_TRIES    = 3,
   parameter int unsigned               LOCKOUT_CYC  = 625_000_000,
   parameter logic [N_DIGITS*4-1:0]     DEFAULT_PASS = 12'h122
) (
   input  logic                clk,
   input  logic                rst_n,
   param_digital_lock_if.slave bus
);
   localparam int CW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNTW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC + 1) : 1;
   localparam int DW   = N_DIGITS * 4;

   localparam logic [1:0] S_LOCKED   = 2'd0;
   localparam logic [1:0] S_UNLOCKED = 2'd1;
   localparam logic [1:0] S_LOCKOUT  = 2'd2;

   localparam logic [3:0]      TRIES_INIT = 4'(MAX_TRIES);
   localparam logic [CNTW-1:0] CNT_LOAD   = CNTW'(LOCKOUT_CYC - 1);

   logic [1:0]      state_q, state_n;
   logic [DW-1:0]   entry_q, entry_n;
   logic [CW-1:0]   cursor_q, cursor_n;
   logic [3:0]      tries_q, tries_n;
   logic [DW-1:0]   pass_q, pass_n;
   logic [CNTW-1:0] cnt_q, cnt_n;
   logic            unlocked_q, lockout_q;
   logic [2:0]      led_q;

   always_comb begin
      state_n  = state_q;
      entry_n  = entry_q;
      cursor_n = cursor_q;
      tries_n  = tries_q;
      pass_n   = pass_q;
      cnt_n    = cnt_q;
      case (state_q)
         S_LOCKOUT: begin
            if (cnt_q == '0) begin
               state_n = S_LOCKED;
               tries_n = TRIES_INIT;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         S_LOCKED, S_UNLOCKED: begin
            if (bus.clr_btn) begin
               entry_n  = '0;
               cursor_n = '0;
            end else if (bus.enter_btn) begin
               entry_n  = '0;
               cursor_n = '0;
               if (state_q == S_LOCKED) begin
                  if (entry_q == pass_q) begin
                     state_n = S_UNLOCKED;
                     tries_n = TRIES_INIT;
                  end else if (tries_q > 4'd1) begin
                     tries_n = tries_q - 4'd1;
                  end else begin
                     tries_n = 4'd0;
                     state_n = S_LOCKOUT;
                     cnt_n   = CNT_LOAD;
                  end
               end else if (bus.mode) begin
                  pass_n = entry_q;
               end else begin
                  state_n = S_LOCKED;
               end
            end else begin
               // Increment uses the old cursor even when pos arrives in the same cycle.
               if (bus.inc_btn) begin
                  for (int i = 0; i < N_DIGITS; i++) begin
                     if (cursor_q == CW'(i)) begin
                        entry_n[i*4 +: 4] = (entry_q[i*4 +: 4] == 4'd9) ? 4'd0
                                                                        : entry_q[i*4 +: 4] + 4'd1;
                     end
                  end
               end
               if (bus.pos_btn) begin
                  cursor_n = (cursor_q == CW'(N_DIGITS - 1)) ? '0 : cursor_q + 1'b1;
               end
            end
         end
         default: state_n = S_LOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOCKED;
         entry_q    <= '0;
         cursor_q   <= '0;
         tries_q    <= TRIES_INIT;
         pass_q     <= DEFAULT_PASS;
         cnt_q      <= '0;
         unlocked_q <= 1'b0;
         lockout_q  <= 1'b0;
         led_q      <= 3'b100;
      end else begin
         state_q    <= state_n;
         entry_q    <= entry_n;
         cursor_q   <= cursor_n;
         tries_q    <= tries_n;
         pass_q     <= pass_n;
         cnt_q      <= cnt_n;
         unlocked_q <= (state_n == S_UNLOCKED);
         lockout_q  <= (state_n == S_LOCKOUT);
         case (state_n)
            S_UNLOCKED: led_q <= 3'b010;
            S_LOCKOUT:  led_q <= 3'b001;
            default:    led_q <= 3'b100;
         endcase
      end
   end

   assign bus.entry      = entry_q;
   assign bus.cursor     = cursor_q;
   assign bus.unlocked   = unlocked_q;
   assign bus.lockout    = lockout_q;
   assign bus.tries_left = tries_q;
   assign bus.led_rgb    = led_q;
endmodule

// File: tb/tb_param_digital_lock.sv
// Directed bench for the keypad lock: a 3-digit instance and a 5-digit single-try instance.
module tb_param_digital_lock;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   param_digital_lock_if #(.N_DIGITS(3)) if3 ();
   param_digital_lock_if #(.N_DIGITS(5)) if5 ();

   param_digital_lock #(
      .N_DIGITS(3), .MAX_TRIES(3), .LOCKOUT_CYC(8), .DEFAULT_PASS(12'h122)
   ) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   param_digital_lock #(
      .N_DIGITS(5), .MAX_TRIES(1), .LOCKOUT_CYC(8), .DEFAULT_PASS(20'h01234)
   ) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int u, input logic p, input logic i, input logic c, input logic e);
      if (u == 0) begin
         if3.pos_btn = p; if3.inc_btn = i; if3.clr_btn = c; if3.enter_btn = e;
      end else begin
         if5.pos_btn = p; if5.inc_btn = i; if5.clr_btn = c; if5.enter_btn = e;
      end
   endtask

   // One-cycle pulse; returns at the falling edge after the sampling edge.
   task automatic pulse(input int u, input logic p, input logic i, input logic c, input logic e);
      @(negedge clk);
      drive(u, p, i, c, e);
      @(negedge clk);
      drive(u, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic key_in(input int u, input logic [19:0] code, input int nd);
      logic [19:0] c;
      c = code;
      pulse(u, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int d = 0; d < nd; d++) begin
         repeat (int'(c[d*4 +: 4])) pulse(u, 1'b0, 1'b1, 1'b0, 1'b0);
         pulse(u, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Hammers every button while lockout is high and counts the lockout cycles.
   task automatic measure_lockout(input int u, output int cyc, output logic edited);
      logic lo;
      cyc = 0;
      edited = 1'b0;
      drive(u, 1'b1, 1'b1, 1'b0, 1'b1);
      lo = (u == 0) ? if3.lockout : if5.lockout;
      while (lo && cyc < 100) begin
         cyc++;
         if (((u == 0) ? 32'(if3.entry) : 32'(if5.entry)) != 0) edited = 1'b1;
         @(negedge clk);
         lo = (u == 0) ? if3.lockout : if5.lockout;
      end
      drive(u, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   cyc;
      logic ed;
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
      if3.mode = 1'b0;
      if5.mode = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_entry", 32'(if3.entry), 32'h0);
      check("rst_cursor", 32'(if3.cursor), 32'h0);
      check("rst_tries", 32'(if3.tries_left), 32'd3);
      check("rst_unlocked", 32'(if3.unlocked), 32'd0);
      check("rst_lockout", 32'(if3.lockout), 32'd0);
      check("rst_led", 32'(if3.led_rgb), 32'h4);

      // T1: key in 122 and unlock
      key_in(0, 20'h122, 3);
      check("t1_entry", 32'(if3.entry), 32'h122);
      check("t1_cursor_wrap", 32'(if3.cursor), 32'h0);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t1_unlocked", 32'(if3.unlocked), 32'd1);
      check("t1_led", 32'(if3.led_rgb), 32'h2);
      check("t1_tries", 32'(if3.tries_left), 32'd3);
      check("t1_entry_clr", 32'(if3.entry), 32'h0);

      // T3: change password to 957, relock, old code fails, new code works
      if3.mode = 1'b1;
      key_in(0, 20'h957, 3);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_stay_unlocked", 32'(if3.unlocked), 32'd1);
      check("t3_entry_clr", 32'(if3.entry), 32'h0);
      if3.mode = 1'b0;
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_relock", 32'(if3.unlocked), 32'd0);
      check("t3_relock_led", 32'(if3.led_rgb), 32'h4);
      key_in(0, 20'h122, 3);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_old_fails", 32'(if3.unlocked), 32'd0);
      check("t3_tries2", 32'(if3.tries_left), 32'd2);
      key_in(0, 20'h957, 3);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_new_unlocks", 32'(if3.unlocked), 32'd1);
      check("t3_tries_restored", 32'(if3.tries_left), 32'd3);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_relock2", 32'(if3.unlocked), 32'd0);

      // T2: three wrong (000) entries then an 8-cycle lockout
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t2_tries2", 32'(if3.tries_left), 32'd2);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t2_tries1", 32'(if3.tries_left), 32'd1);
      check("t2_not_lockout", 32'(if3.lockout), 32'd0);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t2_lockout", 32'(if3.lockout), 32'd1);
      check("t2_led", 32'(if3.led_rgb), 32'h1);
      check("t2_tries0", 32'(if3.tries_left), 32'd0);
      measure_lockout(0, cyc, ed);
      check("t2_lockout_len", 32'(cyc), 32'd8);
      check("t2_ignored", 32'(ed), 32'd0);
      check("t2_back_locked", 32'(if3.led_rgb), 32'h4);
      check("t2_tries_reload", 32'(if3.tries_left), 32'd3);
      check("t2_entry_after", 32'(if3.entry), 32'h0);

      // T4: digit wrap, cursor wrap, inc+pos, clr priority, enter priority
      pulse(0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_inc3", 32'(if3.entry), 32'h003);
      repeat (7) pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_inc_wrap", 32'(if3.entry), 32'h000);
      repeat (3) pulse(0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t4_pos_wrap", 32'(if3.cursor), 32'h0);
      pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse(0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_incpos_entry", 32'(if3.entry), 32'h013);
      check("t4_incpos_cursor", 32'(if3.cursor), 32'h2);
      pulse(0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("t4_clr_inc_entry", 32'(if3.entry), 32'h000);
      check("t4_clr_inc_cursor", 32'(if3.cursor), 32'h0);
      pulse(0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("t4_enter_inc_entry", 32'(if3.entry), 32'h000);
      check("t4_enter_inc_tries", 32'(if3.tries_left), 32'd2);

      // T5: reset mid-lockout restores default password (stored is 957)
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_in_lockout", 32'(if3.lockout), 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_lockout", 32'(if3.lockout), 32'd0);
      check("t5_async_tries", 32'(if3.tries_left), 32'd3);
      check("t5_async_led", 32'(if3.led_rgb), 32'h4);
      @(negedge clk);
      rst_n = 1'b1;
      key_in(0, 20'h122, 3);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_default_unlocks", 32'(if3.unlocked), 32'd1);
      // all-zero password is a valid code
      if3.mode = 1'b1;
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      if3.mode = 1'b0;
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_relock_zero", 32'(if3.unlocked), 32'd0);
      pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_zero_unlocks", 32'(if3.unlocked), 32'd1);

      // T6: 5-digit, single try
      check("t6_rst_tries", 32'(if5.tries_left), 32'd1);
      key_in(1, 20'h01234, 5);
      check("t6_entry", 32'(if5.entry), 32'h01234);
      pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_unlocked", 32'(if5.unlocked), 32'd1);
      pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_relock", 32'(if5.unlocked), 32'd0);
      key_in(1, 20'h01235, 5);
      pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_lockout", 32'(if5.lockout), 32'd1);
      check("t6_tries0", 32'(if5.tries_left), 32'd0);
      measure_lockout(1, cyc, ed);
      check("t6_lockout_len", 32'(cyc), 32'd8);
      check("t6_ignored", 32'(ed), 32'd0);
      check("t6_tries_reload", 32'(if5.tries_left), 32'd1);
      check("t6_led", 32'(if5.led_rgb), 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
